brtag_alloc: RTL and testbench

Branch-tag allocator in the rename/dispatch stage. It hands out the circular WIDTH_BRM-bit branch tags that every dispatched instruction carries as its brmask. It consumes the registered 2^WIDTH_BRM-bit kill vector produced by the branch execute unit and rolls the allocation pointer back on a misprediction. It also frees tags in order as branches commit, and back-pressures dispatch when all tags are outstanding.

---
 rtl/brtag_alloc_pkg.sv | 14 +
 rtl/brtag_alloc_brkill_first.sv | 22 ++
 rtl/brtag_alloc.sv | 48 ++++
 tb/tb_brtag_alloc.sv | 104 ++++++++++
 4 files changed

// File: rtl/brtag_alloc_pkg.sv
// brtag_alloc_pkg: tag-count derivation, kill-vector test and wrapping pointer increment shared with execute
package brtag_alloc_pkg;
  localparam int MAX_W = 8;
  localparam int MAX_NTAG = 1 << MAX_W;
  function automatic int ntag_of(input int w);
    return 1 << w;
  endfunction
  function automatic logic killf(input logic [MAX_NTAG-1:0] kill, input logic [MAX_W-1:0] tag);
    return kill[tag];
  endfunction
  function automatic logic [MAX_W-1:0] ptr_inc(input logic [MAX_W-1:0] p, input int w);
    return (p + 1'b1) & MAX_W'(ntag_of(w) - 1);
  endfunction
endpackage

// File: rtl/brtag_alloc_brkill_first.sv
// brtag_alloc_brkill_first: first set bit of vec_i scanning circularly upward from start_i
module brtag_alloc_brkill_first #(
  parameter int W = 4,
  localparam int N = 1 << W
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  logic [N-1:0] rot;
  logic [W-1:0] off;
  for (genvar j = 0; j < N; j++) begin : g_rot
    assign rot[j] = vec_i[start_i + W'(j)];
  end
  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? W'(k) : off;
  end
  assign found_o = |vec_i;
  assign idx_o = start_i + off;
endmodule

// File: rtl/brtag_alloc.sv
// brtag_alloc: circular branch-tag allocator with in-order commit, kill rollback and full back-pressure
module brtag_alloc
  import brtag_alloc_pkg::*;
#(
  parameter int WIDTH_BRM = 4,
  localparam int NTAG = ntag_of(WIDTH_BRM)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc,
  input  logic                 i_commit,
  input  logic [NTAG-1:0]      i_brkill,
  output logic [WIDTH_BRM-1:0] o_brmask,
  output logic [WIDTH_BRM-1:0] o_alloc_tag,
  output logic                 o_alloc_ack,
  output logic                 o_full,
  output logic [WIDTH_BRM-1:0] o_count,
  output logic [NTAG-1:0]      o_live
);
  logic [WIDTH_BRM-1:0] head_q, head_d, tail_q, tail_d, kill_idx;
  logic kill_hit, commit_ok;
  assign o_count = tail_q - head_q;
  assign o_full = o_count == WIDTH_BRM'(NTAG - 1);
  assign o_brmask = tail_q;
  assign o_alloc_tag = tail_q;
  for (genvar i = 0; i < NTAG; i++) begin : g_live
    assign o_live[i] = WIDTH_BRM'(WIDTH_BRM'(i) - head_q) <= o_count;
  end
  assign o_alloc_ack = i_alloc & ~o_full & ~|i_brkill;
  assign commit_ok = i_commit & (o_count != '0) & ~killf(MAX_NTAG'(i_brkill), MAX_W'(head_q));
  brtag_alloc_brkill_first #(.W(WIDTH_BRM)) u_first (
    .vec_i  (i_brkill & o_live),
    .start_i(head_q),
    .found_o(kill_hit),
    .idx_o  (kill_idx)
  );
  assign head_d = commit_ok ? WIDTH_BRM'(ptr_inc(MAX_W'(head_q), WIDTH_BRM)) : head_q;
  assign tail_d = kill_hit ? kill_idx : o_alloc_ack ? WIDTH_BRM'(ptr_inc(MAX_W'(tail_q), WIDTH_BRM)) : tail_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: tb/tb_brtag_alloc.sv
// tb_brtag_alloc: table-driven directed check of brtag_alloc with WIDTH_BRM=2
module tb_brtag_alloc;
  typedef struct {
    logic       alloc;
    logic       commit;
    logic [3:0] kill;
    logic       ack;
    logic [1:0] tag;
    logic [1:0] mask;
    logic [1:0] cnt;
    logic       full;
    logic [3:0] live;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, alloc = 1'b0, commit = 1'b0;
  logic [3:0] kill = '0;
  logic [1:0] brmask, alloc_tag, count;
  logic ack, full;
  logic [3:0] live;
  int n_chk = 0, n_fail = 0;
  vec_t tv[19];
  always #5 clk = ~clk;
  brtag_alloc #(.WIDTH_BRM(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_alloc    (alloc),
    .i_commit   (commit),
    .i_brkill   (kill),
    .o_brmask   (brmask),
    .o_alloc_tag(alloc_tag),
    .o_alloc_ack(ack),
    .o_full     (full),
    .o_count    (count),
    .o_live     (live)
  );
  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %b expected %b", nm, idx, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int idx);
    alloc = v.alloc;
    commit = v.commit;
    kill = v.kill;
    #1;
    chk("ack", idx, 4'(ack), 4'(v.ack));
    chk("alloc_tag", idx, 4'(alloc_tag), 4'(v.tag));
    @(posedge clk);
    #2;
    chk("brmask", idx, 4'(brmask), 4'(v.mask));
    chk("count", idx, 4'(count), 4'(v.cnt));
    chk("full", idx, 4'(full), 4'(v.full));
    chk("live", idx, live, v.live);
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 4'b0011};
    tv[1]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, 4'b0111};
    tv[2]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd3, 2'd3, 1'b1, 4'b1111};
    tv[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 2'd3, 2'd3, 1'b1, 4'b1111};
    tv[4]  = '{1'b0, 1'b0, 4'b1100, 1'b0, 2'd3, 2'd2, 2'd2, 1'b0, 4'b0111};
    tv[5]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2, 2'd1, 1'b0, 4'b0110};
    tv[6]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd3, 2'd2, 1'b0, 4'b1110};
    tv[7]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd0, 2'd3, 1'b1, 4'b1111};
    tv[8]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 4'b1101};
    tv[9]  = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1, 2'd3, 1'b1, 4'b1111};
    tv[10] = '{1'b0, 1'b0, 4'b0011, 1'b0, 2'd1, 2'd0, 2'd2, 1'b0, 4'b1101};
    tv[11] = '{1'b0, 1'b1, 4'b1000, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 4'b1000};
    tv[12] = '{1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3, 2'd0, 1'b0, 4'b1000};
    tv[13] = '{1'b1, 1'b0, 4'b1111, 1'b0, 2'd3, 2'd3, 2'd0, 1'b0, 4'b1000};
    tv[14] = '{1'b1, 1'b0, 4'b0001, 1'b0, 2'd3, 2'd3, 2'd0, 1'b0, 4'b1000};
    tv[15] = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd0, 2'd1, 1'b0, 4'b1001};
    tv[16] = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 4'b1011};
    tv[17] = '{1'b1, 1'b0, 4'b0010, 1'b0, 2'd1, 2'd1, 2'd2, 1'b0, 4'b1011};
    tv[18] = '{1'b0, 1'b1, 4'b1011, 1'b0, 2'd1, 2'd3, 2'd0, 1'b0, 4'b1000};
    #12;
    chk("rst_brmask", 0, 4'(brmask), 4'd0);
    chk("rst_count", 0, 4'(count), 4'd0);
    chk("rst_full", 0, 4'(full), 4'd0);
    chk("rst_live", 0, live, 4'b0001);
    chk("rst_ack", 0, 4'(ack), 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) step(tv[i], i);
    for (int i = 0; i < 3; i++) step('{1'b1, 1'b0, 4'b0000, 1'b1, 2'(3 + i), 2'(i), 2'(i + 1), i == 2, 4'b1000 | ((4'b0010 << i) - 4'd1)}, 100 + i);
    alloc = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_brmask", 200, 4'(brmask), 4'd0);
    chk("async_count", 200, 4'(count), 4'd0);
    chk("async_full", 200, 4'(full), 4'd0);
    chk("async_live", 200, live, 4'b0001);
    chk("async_ack", 200, 4'(ack), 4'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    step('{1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 4'b0011}, 300);
    step('{1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, 4'b0111}, 301);
    step('{1'b1, 1'b0, 4'b0100, 1'b0, 2'd2, 2'd2, 2'd2, 1'b0, 4'b0111}, 302);
    step('{1'b0, 1'b1, 4'b0111, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0, 4'b0001}, 303);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
